// File: rtl/lr35902_dbg_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lr35902_dbg_monitor_pkg
// Brief   : Shared constants and types for the LR35902 debug snapshot monitor.
// Rev     : 1.0
// ============================================================================
package lr35902_dbg_monitor_pkg;

    localparam int BAUD_DIV_DEFAULT = 12;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int NUM_SLOTS = 12;

    localparam logic [3:0] SLOT_STATUS = 4'd0;
    localparam logic [3:0] SLOT_F      = 4'd1;
    localparam logic [3:0] SLOT_PROBE0 = 4'd2;
    localparam logic [3:0] SLOT_PROBE1 = 4'd3;
    localparam logic [3:0] SLOT_PC0    = 4'd4;
    localparam logic [3:0] SLOT_PC1    = 4'd5;
    localparam logic [3:0] SLOT_PC2    = 4'd6;
    localparam logic [3:0] SLOT_PC3    = 4'd7;
    localparam logic [3:0] SLOT_SP0    = 4'd8;
    localparam logic [3:0] SLOT_SP1    = 4'd9;
    localparam logic [3:0] SLOT_SP2    = 4'd10;
    localparam logic [3:0] SLOT_SP3    = 4'd11;

    localparam logic [NUM_SLOTS-1:0] MASK_FULL = {NUM_SLOTS{1'b1}};

endpackage
`default_nettype wire

// File: rtl/lr35902_dbg_monitor_if.sv
`default_nettype none
// ============================================================================
// Module  : lr35902_dbg_monitor_if
// Brief   : Serial input, error clear and snapshot outputs of the debug monitor.
// Rev     : 1.0
// ============================================================================
interface lr35902_dbg_monitor_if;
    logic        rx;
    logic        clr_err;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [3:0]  status;
    logic [3:0]  f;
    logic [7:0]  probe;
    logic [15:0] pc;
    logic [15:0] sp;
    logic        snap_valid;
    logic        seq_err;
    logic        frame_err;

    modport master (
        output rx, clr_err,
        input  byte_out, byte_valid, status, f, probe, pc, sp,
        input  snap_valid, seq_err, frame_err
    );

    modport slave (
        input  rx, clr_err,
        output byte_out, byte_valid, status, f, probe, pc, sp,
        output snap_valid, seq_err, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/lr35902_dbg_uart_rxbyte.sv
`default_nettype none
// ============================================================================
// Module  : lr35902_dbg_uart_rxbyte
// Brief   : 8N1 deserializer with input synchronizer and framing-error pulse.
// Rev     : 1.0
// ============================================================================
module lr35902_dbg_uart_rxbyte
    import lr35902_dbg_monitor_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_rx,
    output logic      [7:0] o_byte,
    output logic            o_byte_valid,
    output logic            o_frame_err
);
    localparam int SUB_W = $clog2(BAUD_DIV);
    localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(BAUD_DIV / 2 - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BAUD_DIV - 1);

    logic             r_meta, r_sync;
    rx_state_t        r_state, w_state_nxt;
    logic [SUB_W-1:0] r_sub, w_sub_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [7:0]       r_byte, w_byte_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_ferr, w_ferr_nxt;
    logic             w_rx;

    assign w_rx = r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_state <= ST_IDLE;
            r_sub   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_meta  <= i_rx;
            r_sync  <= r_meta;
            r_state <= w_state_nxt;
            r_sub   <= w_sub_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_byte  <= w_byte_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    // Start bit is re-checked at mid-bit so short glitches fall back to idle.
    always_comb begin
        w_state_nxt = r_state;
        w_sub_nxt   = r_sub + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_byte_nxt  = r_byte;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sub_nxt = '0;
                if (!w_rx) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (r_sub == SUB_HALF) begin
                    w_sub_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_sub == SUB_LAST) begin
                    w_sub_nxt   = '0;
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == 3'd7) w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_sub == SUB_LAST) begin
                    w_sub_nxt = '0;
                    if (w_rx) begin
                        w_valid_nxt = 1'b1;
                        w_byte_nxt  = r_shift;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                w_sub_nxt = '0;
                if (w_rx) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_sub_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_valid;
    assign o_frame_err  = r_ferr;

endmodule
`default_nettype wire

// File: rtl/lr35902_dbg_monitor.sv
`default_nettype none
// ============================================================================
// Module  : lr35902_dbg_monitor
// Brief   : Decodes indexed nibble bytes into shadow slots and commits snapshots.
// Rev     : 1.0
// ============================================================================
module lr35902_dbg_monitor
    import lr35902_dbg_monitor_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  wire logic              uart_clk,
    input  wire logic              reset,
    lr35902_dbg_monitor_if.slave   dbg
);
    logic [7:0]                 w_byte;
    logic                       w_byte_valid;
    logic                       w_ferr_evt;
    logic [3:0]                 w_idx, w_nib;
    logic                       w_in_slot, w_seq_hit, w_seq_evt, w_commit;
    logic [NUM_SLOTS-1:0]       w_mask_wr, w_mask_nxt;

    logic [3:0]                 r_exp;
    logic [NUM_SLOTS-1:0]       r_mask;
    logic [NUM_SLOTS-1:0][3:0]  r_shadow;
    logic [3:0]                 r_status, r_f;
    logic [7:0]                 r_probe;
    logic [15:0]                r_pc, r_sp;
    logic                       r_snap_valid, r_seq_err, r_frame_err;

    lr35902_dbg_uart_rxbyte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rxbyte (
        .clk          (uart_clk),
        .rst          (reset),
        .i_rx         (dbg.rx),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_ferr_evt)
    );

    assign w_idx     = w_byte[7:4];
    assign w_nib     = w_byte[3:0];
    assign w_in_slot = (w_idx <= SLOT_SP3);
    assign w_seq_hit = (w_idx == r_exp);
    assign w_seq_evt = w_byte_valid & ~w_seq_hit;
    assign w_mask_wr = w_in_slot ? (NUM_SLOTS'(1) << w_idx) : '0;
    // A resync discards the old mask; the resyncing nibble itself still counts.
    assign w_mask_nxt = (w_seq_hit ? r_mask : '0) | w_mask_wr;
    assign w_commit   = w_byte_valid && (w_idx == SLOT_SP3) && (w_mask_nxt == MASK_FULL);

    always_ff @(posedge uart_clk) begin
        if (reset) begin
            r_exp        <= '0;
            r_mask       <= '0;
            r_shadow     <= '0;
            r_status     <= '0;
            r_f          <= '0;
            r_probe      <= '0;
            r_pc         <= '0;
            r_sp         <= '0;
            r_snap_valid <= 1'b0;
            r_seq_err    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_snap_valid <= w_commit;
            r_seq_err    <= w_seq_evt  | (r_seq_err   & ~dbg.clr_err);
            r_frame_err  <= w_ferr_evt | (r_frame_err & ~dbg.clr_err);
            if (w_byte_valid) begin
                r_exp  <= w_seq_hit ? r_exp + 4'd1 : w_idx + 4'd1;
                r_mask <= (w_idx == SLOT_SP3) ? '0 : w_mask_nxt;
                if (w_in_slot) r_shadow[w_idx] <= w_nib;
                // The SP3 nibble arrives with the commit, so take it from the byte.
                if (w_commit) begin
                    r_status <= r_shadow[SLOT_STATUS];
                    r_f      <= r_shadow[SLOT_F];
                    r_probe  <= {r_shadow[SLOT_PROBE1], r_shadow[SLOT_PROBE0]};
                    r_pc     <= {r_shadow[SLOT_PC3], r_shadow[SLOT_PC2],
                                 r_shadow[SLOT_PC1], r_shadow[SLOT_PC0]};
                    r_sp     <= {w_nib, r_shadow[SLOT_SP2],
                                 r_shadow[SLOT_SP1], r_shadow[SLOT_SP0]};
                end
            end
        end
    end

    assign dbg.byte_out   = w_byte;
    assign dbg.byte_valid = w_byte_valid;
    assign dbg.status     = r_status;
    assign dbg.f          = r_f;
    assign dbg.probe      = r_probe;
    assign dbg.pc         = r_pc;
    assign dbg.sp         = r_sp;
    assign dbg.snap_valid = r_snap_valid;
    assign dbg.seq_err    = r_seq_err;
    assign dbg.frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_lr35902_dbg_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_lr35902_dbg_monitor
// Brief   : Scoreboard bench for the LR35902 debug snapshot monitor.
// Rev     : 1.0
// ============================================================================
module tb_lr35902_dbg_monitor;
    localparam int B   = 12;
    // 2 sync flops + IDLE->START edge, half bit to DATA, 8 data bits, stop bit.
    localparam int LAT = 3 + B / 2 + 9 * B;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } byte_exp_t;

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  f;
        logic [7:0]  probe;
        logic [15:0] pc;
        logic [15:0] sp;
        int          cyc;
    } snap_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    byte_exp_t  byte_q[$];
    snap_exp_t  snap_q[$];
    snap_exp_t  snap_ref;
    logic [7:0] tx_list[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lr35902_dbg_monitor_if dbg();

    lr35902_dbg_monitor #(
        .BAUD_DIV (B)
    ) dut (
        .uart_clk (clk),
        .reset    (rst),
        .dbg      (dbg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        byte_exp_t be;
        snap_exp_t se;
        if (dbg.byte_valid === 1'b1) begin
            if (byte_q.size() == 0) begin
                chk("byte_valid_unexpected", {31'd0, dbg.byte_valid}, 32'd0);
            end else begin
                be = byte_q.pop_front();
                chk("byte_out", {24'd0, dbg.byte_out}, {24'd0, be.data});
                chk("byte_valid_cycle", cyc, be.cyc);
            end
        end
        if (dbg.snap_valid === 1'b1) begin
            if (snap_q.size() == 0) begin
                chk("snap_valid_unexpected", {31'd0, dbg.snap_valid}, 32'd0);
            end else begin
                se = snap_q.pop_front();
                chk("snap_status", {28'd0, dbg.status}, {28'd0, se.st});
                chk("snap_f", {28'd0, dbg.f}, {28'd0, se.f});
                chk("snap_probe", {24'd0, dbg.probe}, {24'd0, se.probe});
                chk("snap_pc", {16'd0, dbg.pc}, {16'd0, se.pc});
                chk("snap_sp", {16'd0, dbg.sp}, {16'd0, se.sp});
                chk("snap_cycle", cyc, se.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        dbg.clr_err = 1'b1;
        idle(1);
        dbg.clr_err = 1'b0;
        idle(1);
    endtask

    // good_stop=0 holds the stop bit low for two bit times.
    task automatic send_frame(input logic [7:0] b, input bit good_stop,
                              input bit clr_at_valid, input bit push_snap);
        int          t0;
        logic [9:0]  fr;
        byte_exp_t   be;
        snap_exp_t   se;
        @(posedge clk);
        #1;
        t0 = cyc;
        fr = {good_stop, b, 1'b0};
        if (good_stop) begin
            be.data = b;
            be.cyc  = t0 + LAT;
            byte_q.push_back(be);
        end
        if (push_snap) begin
            se     = snap_ref;
            se.cyc = t0 + LAT + 1;
            snap_q.push_back(se);
        end
        for (int j = 0; j < 10; j++) begin
            dbg.rx = fr[j];
            for (int c = 0; c < B; c++) begin
                @(posedge clk);
                #1;
                if (clr_at_valid) dbg.clr_err = (cyc == t0 + LAT);
            end
        end
        if (!good_stop) idle(B);
        dbg.rx = 1'b1;
    endtask

    task automatic load_seq(input bit skip44);
        tx_list = {8'h09, 8'h1F, 8'h2C, 8'h33, 8'h44, 8'h53,
                   8'h62, 8'h71, 8'h8E, 8'h9F, 8'hAF, 8'hBC};
        if (skip44) tx_list.delete(4);
    endtask

    task automatic send_list(input bit expect_snap);
        for (int i = 0; i < tx_list.size(); i++)
            send_frame(tx_list[i], 1'b1, 1'b0, expect_snap && (i == tx_list.size() - 1));
    endtask

    task automatic check_snap_outputs(input string tag);
        chk({tag, "_status"}, {28'd0, dbg.status}, {28'd0, snap_ref.st});
        chk({tag, "_f"}, {28'd0, dbg.f}, {28'd0, snap_ref.f});
        chk({tag, "_probe"}, {24'd0, dbg.probe}, {24'd0, snap_ref.probe});
        chk({tag, "_pc"}, {16'd0, dbg.pc}, {16'd0, snap_ref.pc});
        chk({tag, "_sp"}, {16'd0, dbg.sp}, {16'd0, snap_ref.sp});
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_byte_out"}, {24'd0, dbg.byte_out}, 32'd0);
        chk({tag, "_byte_valid"}, {31'd0, dbg.byte_valid}, 32'd0);
        chk({tag, "_status"}, {28'd0, dbg.status}, 32'd0);
        chk({tag, "_f"}, {28'd0, dbg.f}, 32'd0);
        chk({tag, "_probe"}, {24'd0, dbg.probe}, 32'd0);
        chk({tag, "_pc"}, {16'd0, dbg.pc}, 32'd0);
        chk({tag, "_sp"}, {16'd0, dbg.sp}, 32'd0);
        chk({tag, "_snap_valid"}, {31'd0, dbg.snap_valid}, 32'd0);
        chk({tag, "_seq_err"}, {31'd0, dbg.seq_err}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, dbg.frame_err}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] fr;
        rst         = 1'b1;
        dbg.rx      = 1'b1;
        dbg.clr_err = 1'b0;
        snap_ref    = '{st: 4'h9, f: 4'hF, probe: 8'h3C, pc: 16'h1234, sp: 16'hCFFE, cyc: 0};
        idle(4);
        check_all_zero("reset");
        rst = 1'b0;
        idle(3);

        // Single frame: data and timing checked by the monitor; idx 5 != 0.
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("seq_err_after_5A", {31'd0, dbg.seq_err}, 32'd1);
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        pulse_clr();
        chk("seq_err_cleared", {31'd0, dbg.seq_err}, 32'd0);

        // Full nibble sequence commits a snapshot.
        load_seq(1'b0);
        send_list(1'b1);
        idle(3);
        check_snap_outputs("commit");
        chk("seq_err_full_seq", {31'd0, dbg.seq_err}, 32'd0);
        chk("frame_err_full_seq", {31'd0, dbg.frame_err}, 32'd0);

        // idx 12..15 only advance exp, wrapping it back to 0.
        tx_list = {8'hC0, 8'hD1, 8'hE2, 8'hF3};
        send_list(1'b0);
        idle(2);
        chk("seq_err_idx12_15", {31'd0, dbg.seq_err}, 32'd0);

        // Missing PC nibble: resync error, no commit, outputs hold.
        load_seq(1'b1);
        send_list(1'b0);
        idle(3);
        chk("seq_err_gap", {31'd0, dbg.seq_err}, 32'd1);
        check_snap_outputs("hold");

        // clr_err coincident with a sequence error: the error wins.
        pulse_clr();
        chk("seq_err_pre_race", {31'd0, dbg.seq_err}, 32'd0);
        send_frame(8'h05, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("seq_err_race", {31'd0, dbg.seq_err}, 32'd1);

        // Stop bit low for two bit times, then a good frame.
        pulse_clr();
        send_frame(8'h66, 1'b0, 1'b0, 1'b0);
        idle(B);
        chk("frame_err_set", {31'd0, dbg.frame_err}, 32'd1);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("frame_err_sticky", {31'd0, dbg.frame_err}, 32'd1);
        pulse_clr();
        chk("frame_err_cleared", {31'd0, dbg.frame_err}, 32'd0);
        chk("seq_err_cleared2", {31'd0, dbg.seq_err}, 32'd0);

        // Short low glitch is ignored.
        dbg.rx = 1'b0;
        idle(B / 4);
        dbg.rx = 1'b1;
        idle(3 * B);
        chk("glitch_frame_err", {31'd0, dbg.frame_err}, 32'd0);
        chk("glitch_seq_err", {31'd0, dbg.seq_err}, 32'd0);

        // Reset in the middle of data bit 3.
        fr = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 4; j++) begin
            dbg.rx = fr[j];
            idle((j == 3) ? B / 2 : B);
        end
        rst    = 1'b1;
        dbg.rx = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        check_all_zero("midframe_reset");
        send_frame(8'h03, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("seq_err_after_reset", {31'd0, dbg.seq_err}, 32'd0);

        idle(4);
        chk("byte_q_drained", byte_q.size(), 32'd0);
        chk("snap_q_drained", snap_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
